// File: rtl/cpu_seq_pkg.sv
// Shared encodings for the multi-cycle CPU sequencer: states, instruction
// classes (shared with the decoder), bus mux selects and the strobe bundle.
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_HALT   = 3'd4,
    S_FAULT  = 3'd5,
    S_IRQ    = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU    = 3'd0,
    CLS_MOV    = 3'd1,
    CLS_CMP    = 3'd2,
    CLS_LOAD   = 3'd3,
    CLS_STORE  = 3'd4,
    CLS_BRANCH = 3'd5,
    CLS_JAL    = 3'd6,
    CLS_HALT   = 3'd7
  } instr_class_t;

  typedef enum logic [1:0] {
    BUS_MEM  = 2'd0,
    BUS_ALU  = 2'd1,
    BUS_LINK = 2'd2
  } bus_sel_t;

  typedef struct packed {
    logic     mem_req;
    logic     mem_we;
    logic     addr_sel;
    logic     ir_enable;
    logic     pc_enable;
    logic     pc_load;
    logic     reg_we;
    logic     flags_we;
    bus_sel_t bus_sel;
  } strobes_t;

  localparam strobes_t STROBES_IDLE = '{
    mem_req: 1'b0, mem_we: 1'b0, addr_sel: 1'b0, ir_enable: 1'b0,
    pc_enable: 1'b0, pc_load: 1'b0, reg_we: 1'b0, flags_we: 1'b0,
    bus_sel: BUS_ALU
  };

endpackage

// File: rtl/cpu_seq_ctrl_seq_wait_timer.sv
// Memory-wait counter: counts stalled FETCH/MEM cycles, saturates, and flags
// the last permitted stall cycle so the sequencer can fault on the next edge.
module seq_wait_timer #(
  parameter int TMO_W       = 8,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic mem_ready,
  output logic timeout
);

  localparam int unsigned LIMIT = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

  logic [TMO_W-1:0] cnt;

  // NOTE: synchronous reset, so reset sits inside the clocked branch only.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (!active || mem_ready) begin
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

  // A ready in the limit cycle suppresses the timeout, so completion wins.
  assign timeout = (MEM_TIMEOUT > 0) && active && !mem_ready && (32'(cnt) == LIMIT);

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer with variable-latency memory,
// retired counter and timeout fault. Optional interrupt entry: CPU_SEQ_IRQ_EN.
module cpu_seq_ctrl
  import cpu_seq_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int TMO_W       = 8,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       instr_class,
  input  logic             cond_true,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_enable,
  output logic             pc_enable,
  output logic             pc_load,
  output logic             reg_we,
  output logic             flags_we,
  output logic [1:0]       bus_sel,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state_out,
  output logic             fault,
  output logic             halted
`ifdef CPU_SEQ_IRQ_EN
  , input  logic           irq
  , output logic           irq_ack
  , output logic           epc_we
  , output logic           vec_load
`endif
);

  state_t       state, state_d;
  instr_class_t cls;
  strobes_t     stb_c, stb;
  logic         timeout, retire, halt_entry;

  assign cls = instr_class_t'(instr_class);

`ifdef CPU_SEQ_IRQ_EN
  logic irq_q, pending;

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q   <= 1'b0;
      pending <= 1'b0;
    end else begin
      irq_q <= irq;
      // A new edge outranks the clear so an edge during IRQ stays pending.
      if (irq && !irq_q)     pending <= 1'b1;
      else if (state == S_IRQ) pending <= 1'b0;
    end
  end

  assign irq_ack  = !reset && (state == S_IRQ);
  assign epc_we   = irq_ack;
  assign vec_load = irq_ack;
`endif

  seq_wait_timer #(
    .TMO_W       (TMO_W),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .active    ((state == S_FETCH) || (state == S_MEM)),
    .mem_ready (mem_ready),
    .timeout   (timeout)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_d;
  end

  // NOTE: every output of this block gets a default first; no latches.
  always_comb begin
    stb_c      = STROBES_IDLE;
    state_d    = state;
    halt_entry = 1'b0;
    case (state)
      S_FETCH: begin
        stb_c.mem_req = 1'b1;
        if (mem_ready) begin
          stb_c.ir_enable = 1'b1;
          state_d         = S_DECODE;
        end else if (timeout) begin
          state_d = S_FAULT;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        state_d = S_FETCH;
        case (cls)
          CLS_ALU: begin
            stb_c.reg_we    = 1'b1;
            stb_c.flags_we  = 1'b1;
            stb_c.pc_enable = 1'b1;
          end
          CLS_MOV: begin
            stb_c.reg_we    = 1'b1;
            stb_c.pc_enable = 1'b1;
          end
          CLS_CMP: begin
            stb_c.flags_we  = 1'b1;
            stb_c.pc_enable = 1'b1;
          end
          CLS_LOAD, CLS_STORE: state_d = S_MEM;
          CLS_BRANCH: begin
            stb_c.pc_load   = cond_true;
            stb_c.pc_enable = !cond_true;
          end
          CLS_JAL: begin
            stb_c.reg_we  = 1'b1;
            stb_c.bus_sel = BUS_LINK;
            stb_c.pc_load = 1'b1;
          end
          default: begin
            halt_entry = 1'b1;
            state_d    = S_HALT;
          end
        endcase
      end
      S_MEM: begin
        stb_c.mem_req  = 1'b1;
        stb_c.addr_sel = 1'b1;
        stb_c.mem_we   = (cls == CLS_STORE);
        if (mem_ready) begin
          if (cls == CLS_LOAD) begin
            stb_c.reg_we  = 1'b1;
            stb_c.bus_sel = BUS_MEM;
          end
          stb_c.pc_enable = 1'b1;
          state_d         = S_FETCH;
        end else if (timeout) begin
          state_d = S_FAULT;
        end
      end
      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
`ifdef CPU_SEQ_IRQ_EN
      S_IRQ:   state_d = S_FETCH;
`endif
      default: state_d = S_FETCH;
    endcase

    retire = stb_c.pc_enable || stb_c.pc_load || halt_entry;
`ifdef CPU_SEQ_IRQ_EN
    if (retire && pending && (state_d == S_FETCH)) state_d = S_IRQ;
`endif
  end

  // Reset overrides the decoded strobes so an aborted access never writes.
  assign stb = reset ? STROBES_IDLE : stb_c;

  always_ff @(posedge clk) begin
    if (reset)       retired <= '0;
    else if (retire) retired <= retired + 1'b1;
  end

  assign mem_req   = stb.mem_req;
  assign mem_we    = stb.mem_we;
  assign addr_sel  = stb.addr_sel;
  assign ir_enable = stb.ir_enable;
  assign pc_enable = stb.pc_enable;
  assign pc_load   = stb.pc_load;
  assign reg_we    = stb.reg_we;
  assign flags_we  = stb.flags_we;
  assign bus_sel   = stb.bus_sel;
  assign state_out = state;
  assign fault     = (state == S_FAULT);
  assign halted    = (state == S_HALT);

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Scoreboard bench for cpu_seq_ctrl (CNT_W=4, MEM_TIMEOUT=4): directed
// per-cycle vectors push expected outputs; a monitor pops and compares.
module tb_cpu_seq_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [2:0]       instr_class;
  logic             cond_true;
  logic             mem_ready;
  logic             mem_req, mem_we, addr_sel, ir_enable, pc_enable, pc_load;
  logic             reg_we, flags_we, fault, halted;
  logic [1:0]       bus_sel;
  logic [CNT_W-1:0] retired;
  logic [2:0]       state_out;
`ifdef CPU_SEQ_IRQ_EN
  logic irq = 1'b0;
  logic irq_ack, epc_we, vec_load;
`endif

  cpu_seq_ctrl #(.CNT_W(CNT_W), .TMO_W(8), .MEM_TIMEOUT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_class (instr_class),
    .cond_true   (cond_true),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .addr_sel    (addr_sel),
    .ir_enable   (ir_enable),
    .pc_enable   (pc_enable),
    .pc_load     (pc_load),
    .reg_we      (reg_we),
    .flags_we    (flags_we),
    .bus_sel     (bus_sel),
    .retired     (retired),
    .state_out   (state_out),
    .fault       (fault),
    .halted      (halted)
`ifdef CPU_SEQ_IRQ_EN
    , .irq       (irq)
    , .irq_ack   (irq_ack)
    , .epc_we    (epc_we)
    , .vec_load  (vec_load)
`endif
  );

  always #5 clk = ~clk;

  // {state, mem_req, mem_we, addr_sel, ir_enable, pc_enable, pc_load,
  //  reg_we, flags_we, bus_sel, retired, fault, halted}
  typedef struct {
    string       name;
    logic [18:0] v;
  } item_t;

  item_t q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  localparam logic [2:0] ALU = 3'd0, MOV = 3'd1, CMP = 3'd2, LD = 3'd3,
                         ST = 3'd4, BR = 3'd5, JAL = 3'd6, HLT = 3'd7;
  localparam logic [7:0] S_NONE  = 8'b0000_0000,
                         S_FETCH = 8'b1000_0000,
                         S_FTCH1 = 8'b1001_0000,
                         S_MEMW  = 8'b1010_0000;

  // Drive one cycle of inputs and record what the DUT must show in it.
  task automatic step(input string nm, input logic rst, input logic [2:0] cls,
                      input logic cnd, input logic rdy, input logic [2:0] st,
                      input logic [7:0] stb, input logic [1:0] bus,
                      input logic [3:0] ret, input logic flt, input logic hlt);
    item_t it;
    @(negedge clk);
    reset       = rst;
    instr_class = cls;
    cond_true   = cnd;
    mem_ready   = rdy;
    it.name = nm;
    it.v    = {st, stb, bus, ret, flt, hlt};
    q.push_back(it);
  endtask

  // Three-cycle instruction with ready tied high; exec strobes given.
  task automatic instr3(input string nm, input logic [2:0] cls, input logic cnd,
                        input logic [7:0] exec_stb, input logic [1:0] exec_bus,
                        input logic [3:0] ret);
    step({nm, "_fetch"},  1'b0, cls, cnd, 1'b1, 3'd0, S_FTCH1, 2'd1, ret, 1'b0, 1'b0);
    step({nm, "_decode"}, 1'b0, cls, cnd, 1'b1, 3'd1, S_NONE,  2'd1, ret, 1'b0, 1'b0);
    step({nm, "_exec"},   1'b0, cls, cnd, 1'b1, 3'd2, exec_stb, exec_bus, ret, 1'b0, 1'b0);
  endtask

  initial begin : monitor
    item_t       it;
    logic [18:0] act;
    forever begin
      @(negedge clk);
      #4;
      if (q.size() > 0) begin
        it  = q.pop_front();
        act = {state_out, mem_req, mem_we, addr_sel, ir_enable, pc_enable,
               pc_load, reg_we, flags_we, bus_sel, retired, fault, halted};
        n_tests++;
        if (act !== it.v) begin
          n_fail++;
          $display("FAIL %s: got %b want %b", it.name, act, it.v);
        end
      end
    end
  end

  initial begin : stimulus
    reset = 1'b1; instr_class = ALU; cond_true = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);

    step("reset", 1'b1, ALU, 1'b0, 1'b1, 3'd0, S_NONE, 2'd1, 4'd0, 1'b0, 1'b0);

    instr3("alu", ALU, 1'b0, 8'b0000_1011, 2'd1, 4'd0);

    // LOAD: three stalled MEM cycles, ready on the timeout-limit cycle
    step("ld_fetch",  1'b0, LD, 1'b0, 1'b1, 3'd0, S_FTCH1, 2'd1, 4'd1, 1'b0, 1'b0);
    step("ld_decode", 1'b0, LD, 1'b0, 1'b1, 3'd1, S_NONE,  2'd1, 4'd1, 1'b0, 1'b0);
    step("ld_exec",   1'b0, LD, 1'b0, 1'b1, 3'd2, S_NONE,  2'd1, 4'd1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step("ld_wait", 1'b0, LD, 1'b0, 1'b0, 3'd3, S_MEMW, 2'd1, 4'd1, 1'b0, 1'b0);
    step("ld_done",   1'b0, LD, 1'b0, 1'b1, 3'd3, 8'b1010_1010, 2'd0, 4'd1, 1'b0, 1'b0);

    step("st_fetch",  1'b0, ST, 1'b0, 1'b1, 3'd0, S_FTCH1, 2'd1, 4'd2, 1'b0, 1'b0);
    step("st_decode", 1'b0, ST, 1'b0, 1'b1, 3'd1, S_NONE,  2'd1, 4'd2, 1'b0, 1'b0);
    step("st_exec",   1'b0, ST, 1'b0, 1'b1, 3'd2, S_NONE,  2'd1, 4'd2, 1'b0, 1'b0);
    step("st_mem",    1'b0, ST, 1'b0, 1'b1, 3'd3, 8'b1110_1000, 2'd1, 4'd2, 1'b0, 1'b0);

    instr3("br_taken", BR,  1'b1, 8'b0000_0100, 2'd1, 4'd3);
    instr3("br_not",   BR,  1'b0, 8'b0000_1000, 2'd1, 4'd4);
    instr3("cmp",      CMP, 1'b0, 8'b0000_1001, 2'd1, 4'd5);
    instr3("jal",      JAL, 1'b1, 8'b0000_0110, 2'd2, 4'd6);
    instr3("mov",      MOV, 1'b0, 8'b0000_1010, 2'd1, 4'd7);

    // Ten CMPs: retired runs 8..15 then wraps to 0, 1
    for (int i = 0; i < 10; i++)
      instr3("cmp_wrap", CMP, 1'b0, 8'b0000_1001, 2'd1, 4'((8 + i) % 16));

    instr3("halt", HLT, 1'b0, S_NONE, 2'd1, 4'd2);
    step("halted",     1'b0, ALU, 1'b0, 1'b1, 3'd4, S_NONE, 2'd1, 4'd3, 1'b0, 1'b1);
    step("halt_hold",  1'b0, LD,  1'b1, 1'b1, 3'd4, S_NONE, 2'd1, 4'd3, 1'b0, 1'b1);
    step("halt_reset", 1'b1, ALU, 1'b0, 1'b1, 3'd4, S_NONE, 2'd1, 4'd3, 1'b0, 1'b1);

    // Fetch stuck: four wait cycles, then FAULT
    for (int i = 0; i < 4; i++)
      step("tmo_wait", 1'b0, ALU, 1'b0, 1'b0, 3'd0, S_FETCH, 2'd1, 4'd0, 1'b0, 1'b0);
    step("fault",       1'b0, ALU, 1'b0, 1'b1, 3'd5, S_NONE, 2'd1, 4'd0, 1'b1, 1'b0);
    step("fault_hold",  1'b0, ST,  1'b1, 1'b1, 3'd5, S_NONE, 2'd1, 4'd0, 1'b1, 1'b0);
    step("fault_reset", 1'b1, ALU, 1'b0, 1'b1, 3'd5, S_NONE, 2'd1, 4'd0, 1'b1, 1'b0);

    // Reset during a LOAD memory wait must abort with no register write
    step("rl_fetch",  1'b0, LD, 1'b0, 1'b1, 3'd0, S_FTCH1, 2'd1, 4'd0, 1'b0, 1'b0);
    step("rl_decode", 1'b0, LD, 1'b0, 1'b1, 3'd1, S_NONE,  2'd1, 4'd0, 1'b0, 1'b0);
    step("rl_exec",   1'b0, LD, 1'b0, 1'b0, 3'd2, S_NONE,  2'd1, 4'd0, 1'b0, 1'b0);
    step("rl_wait",   1'b0, LD, 1'b0, 1'b0, 3'd3, S_MEMW,  2'd1, 4'd0, 1'b0, 1'b0);
    step("rl_abort",  1'b1, LD, 1'b0, 1'b1, 3'd3, S_NONE,  2'd1, 4'd0, 1'b0, 1'b0);
    step("rl_after",  1'b0, LD, 1'b0, 1'b0, 3'd0, S_FETCH, 2'd1, 4'd0, 1'b0, 1'b0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries never compared, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_seq_ctrl.md
Name: cpu_seq_ctrl

Overview:
- Parametrised multi-cycle sequencer for the 16-bit CPU; next generation of the fixed fetch/decode/execute controller.
- Sits between the instruction decoder (supplies instruction class and condition result) and the datapath (PC, IR, register bank, flag register, bus mux, BRAM port A).
- Adds a variable-latency memory handshake, per-class sequencing (ALU, compare, load, store, branch, jump-and-link, halt), a retired-instruction counter, and a memory timeout fault.

Parameters:
- CNT_W, 16, width of retired-instruction counter
- TMO_W, 8, width of memory-wait counter
- MEM_TIMEOUT, 64, wait cycles before fault; 0 disables timeout

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- instr_class  in  3  from decoder: 0 ALU, 1 MOV/LUI (no flags), 2 CMP, 3 LOAD, 4 STORE, 5 BRANCH, 6 JAL, 7 HALT
- cond_true  in  1  branch condition met (sampled in EXEC)
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request active
- mem_we  out  1  write strobe (STORE)
- addr_sel  out  1  0 = PC drives address, 1 = register drives address
- ir_enable  out  1  load instruction register
- pc_enable  out  1  PC += 1
- pc_load  out  1  PC <= target
- reg_we  out  1  register bank write
- flags_we  out  1  flag register write
- bus_sel  out  2  0 = memory, 1 = ALU, 2 = PC+1 link
- retired  out  CNT_W  retired-instruction count
- state_out  out  3  current state encoding
- fault  out  1  sticky memory-timeout fault
- halted  out  1  in HALT

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, HALT=4, FAULT=5.
- Reset:
  - state FETCH; retired 0; wait counter 0; fault 0.
  - All strobes are 0 and bus_sel is 1 in the reset cycle.
  - Reset in any state, including mid memory wait, aborts the operation with no write.
- Strobes are Moore/Mealy combinational from state, instr_class, cond_true and mem_ready. Default 0.
- FETCH:
  - mem_req=1, addr_sel=0.
  - On mem_ready: ir_enable=1, go to DECODE. Same-cycle ready is legal (1-cycle fetch minimum).
- DECODE: single-cycle settle, no strobes; go to EXEC.
- EXEC by class:
  - ALU: reg_we, flags_we, bus_sel=1, pc_enable; go to FETCH.
  - MOV/LUI: reg_we, bus_sel=1, pc_enable; go to FETCH.
  - CMP: flags_we, pc_enable; go to FETCH.
  - LOAD/STORE: go to MEM, no strobes.
  - BRANCH: cond_true ? pc_load : pc_enable; go to FETCH.
  - JAL: reg_we, bus_sel=2, pc_load; go to FETCH.
  - HALT: go to HALT; pc unchanged.
- MEM:
  - mem_req=1, addr_sel=1, mem_we=(class==STORE), held stable until ready.
  - On mem_ready: LOAD sets reg_we with bus_sel=0; both classes set pc_enable; go to FETCH.
- Retirement:
  - retired += 1 on every cycle that asserts pc_enable or pc_load.
  - Wraps modulo 2^CNT_W.
  - HALT entry also counts once.
- Timeout:
  - Wait counter increments each FETCH/MEM cycle without mem_ready.
  - Counter clears on ready or on state change.
  - If MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT-1 with ready still low, go to FAULT next cycle.
  - In FAULT: fault=1, all strobes 0, held until reset.
  - A ready arriving in the same cycle as the limit wins (normal completion).
  - Counter saturates at 2^TMO_W-1.
- HALT: halted=1, no strobes, held until reset. instr_class is ignored in HALT, FAULT and FETCH.
- Exactly one of pc_enable/pc_load is asserted per retired instruction; never both.

Optional Feature:
- Macro: CPU_SEQ_IRQ_EN.
- Added ports:
  - irq in 1
  - irq_ack out 1
  - epc_we out 1
  - vec_load out 1
- Rising edge of irq latches a pending bit.
- On any retirement cycle with pending=1, the next state is IRQ (encoding 6) instead of FETCH.
- IRQ state, one cycle: epc_we=1 (EPC takes updated PC), vec_load=1, irq_ack=1, clear pending; go to FETCH.
- An edge during the IRQ state is held pending.
- Without the macro: ports absent, state 6 unreachable, behaviour as above.

Decomposition:
- Package cpu_seq_pkg holds:
  - state encodings
  - instr_class encodings (shared with decoder)
  - bus_sel encodings
- One sub-module, seq_wait_timer: wait counter and timeout compare, parametrised by TMO_W/MEM_TIMEOUT.

Test Plan:
- Reset then ALU class, ready tied 1 -> states 0,1,2,0; EXEC cycle shows reg_we=flags_we=pc_enable=1, bus_sel=1; retired=1 after 3 cycles.
- LOAD with ready delayed 3 cycles in MEM -> mem_req/addr_sel=1 held 4 cycles; reg_we with bus_sel=0 only on ready cycle; mem_we=0.
- BRANCH with cond_true=1 then cond_true=0 -> pc_load=1 then pc_enable=1; never both; retired=2.
- MEM_TIMEOUT=4, ready stuck low in FETCH -> FAULT after 4 wait cycles; fault=1, all strobes 0; reset returns to FETCH with fault=0.
- CNT_W=4, 16 CMP instructions -> retired wraps 15->0; HALT class -> halted=1, retired +1, no further strobes.
- (CPU_SEQ_IRQ_EN) irq pulse during LOAD MEM wait -> load completes, then one IRQ cycle with epc_we=vec_load=irq_ack=1, then FETCH.
